// File: rtl/tl45_wb_arbiter.sv
// tl45_wb_arbiter: two-master (A = fetch, B = load/store) to one-slave pipelined Wishbone arbiter with bus watchdog
//
// Ports:
//   i_clk, i_reset               clock, synchronous active-high reset
//   i_{a,b}_cyc/stb/we           master cycle, strobe, write enable
//   i_{a,b}_addr/data/sel        master word address, write data, byte lanes
//   o_{a,b}_ack/stall/err        per-master responses (non-owner: stall=1, ack=err=0)
//   o_{a,b}_data                 read data, straight copy of i_wb_data
//   o_wb_cyc/stb/we/addr/data/sel  slave-side request, copy of the owner's inputs
//   i_wb_ack/stall/err/data      slave responses
module tl45_wb_arbiter #(
    parameter int AW      = 30,
    parameter int DW      = 32,
    parameter int OPT_RR  = 0,
    parameter int TIMEOUT = 1023
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_a_cyc,
    input  logic            i_a_stb,
    input  logic            i_a_we,
    input  logic [AW-1:0]   i_a_addr,
    input  logic [DW-1:0]   i_a_data,
    input  logic [DW/8-1:0] i_a_sel,
    output logic            o_a_ack,
    output logic            o_a_stall,
    output logic            o_a_err,
    output logic [DW-1:0]   o_a_data,
    input  logic            i_b_cyc,
    input  logic            i_b_stb,
    input  logic            i_b_we,
    input  logic [AW-1:0]   i_b_addr,
    input  logic [DW-1:0]   i_b_data,
    input  logic [DW/8-1:0] i_b_sel,
    output logic            o_b_ack,
    output logic            o_b_stall,
    output logic            o_b_err,
    output logic [DW-1:0]   o_b_data,
    output logic            o_wb_cyc,
    output logic            o_wb_stb,
    output logic            o_wb_we,
    output logic [AW-1:0]   o_wb_addr,
    output logic [DW-1:0]   o_wb_data,
    output logic [DW/8-1:0] o_wb_sel,
    input  logic            i_wb_ack,
    input  logic            i_wb_stall,
    input  logic            i_wb_err,
    input  logic [DW-1:0]   i_wb_data
);
    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] OWN_A = 2'd1;
    localparam logic [1:0] OWN_B = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] outs_q, outs_d, wd_q, wd_d;
    logic          last_q, last_d;
    logic          blk_a_q, blk_a_d, blk_b_q, blk_b_d;
    logic          kill_q, kill_d;
    logic          own_a, own_b, own, own_cyc, own_stb, live;
    logic          req_a, req_b, win_b, rel, abort, killed, wb_cyc, wb_stb;

    assign own_a   = state_q == OWN_A;
    assign own_b   = state_q == OWN_B;
    assign own     = own_a | own_b;
    assign own_cyc = own_a ? i_a_cyc : own_b & i_b_cyc;
    assign own_stb = own_a ? i_a_stb : own_b & i_b_stb;
    assign live    = own & ~i_reset;
    // a master that was aborted may not be re-granted until it lets go of cyc
    assign req_a   = i_a_cyc & i_a_stb & ~blk_a_q;
    assign req_b   = i_b_cyc & i_b_stb & ~blk_b_q;
    // last_q = 1 means B held the bus last, so A wins the next tie
    assign win_b   = (req_a & req_b) ? ((OPT_RR != 0) ? ~last_q : 1'b1) : req_b;
    assign rel     = own & ~own_cyc;
    assign abort   = own & ~kill_q & (outs_q != '0) & ~i_wb_ack & ~i_wb_err & (wd_q == CW'(TIMEOUT - 1));
    // kill_q holds the bus low after a slave error until the owner drops cyc
    assign killed  = kill_q | abort;
    assign wb_cyc  = live & own_cyc & ~killed;
    assign wb_stb  = wb_cyc & own_stb;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            outs_q  <= '0;
            wd_q    <= '0;
            last_q  <= 1'b1;
            blk_a_q <= 1'b0;
            blk_b_q <= 1'b0;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            outs_q  <= outs_d;
            wd_q    <= wd_d;
            last_q  <= last_d;
            blk_a_q <= blk_a_d;
            blk_b_q <= blk_b_d;
            kill_q  <= kill_d;
        end
    end

    always_comb begin
        state_d = abort ? IDLE
                : own_a ? (i_a_cyc ? OWN_A : req_b ? OWN_B : IDLE)
                : own_b ? (i_b_cyc ? OWN_B : req_a ? OWN_A : IDLE)
                : (req_a | req_b) ? (win_b ? OWN_B : OWN_A) : IDLE;
        last_d  = (state_d == OWN_A) ? 1'b0 : (state_d == OWN_B) ? 1'b1 : last_q;
        blk_a_d = (abort & own_a) | (blk_a_q & i_a_cyc);
        blk_b_d = (abort & own_b) | (blk_b_q & i_b_cyc);
        kill_d  = own & ~rel & ~abort & (kill_q | i_wb_err);
        outs_d  = (~own | rel | i_wb_err | abort | kill_q) ? '0
                : outs_q + CW'(wb_stb & ~i_wb_stall) - CW'(i_wb_ack & (outs_q != '0));
        wd_d    = (~own | rel | i_wb_ack | i_wb_err | abort | kill_q | (outs_q == '0)) ? '0
                : wd_q + 1'b1;
    end

    always_comb begin
        o_wb_cyc  = wb_cyc;
        o_wb_stb  = wb_stb;
        o_wb_we   = live & (own_a ? i_a_we : i_b_we);
        o_wb_addr = live ? (own_a ? i_a_addr : i_b_addr) : '0;
        o_wb_data = live ? (own_a ? i_a_data : i_b_data) : '0;
        o_wb_sel  = live ? (own_a ? i_a_sel : i_b_sel) : '0;
        o_a_ack   = live & own_a & ~kill_q & i_wb_ack;
        o_b_ack   = live & own_b & ~kill_q & i_wb_ack;
        o_a_err   = live & own_a & ((~kill_q & i_wb_err) | abort);
        o_b_err   = live & own_b & ((~kill_q & i_wb_err) | abort);
        o_a_stall = (live & own_a & ~killed) ? i_wb_stall : 1'b1;
        o_b_stall = (live & own_b & ~killed) ? i_wb_stall : 1'b1;
        o_a_data  = i_wb_data;
        o_b_data  = i_wb_data;
    end
endmodule
